vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

- Generates raster coordinates and sync/blanking for the 640x480@60 HDMI/VGA output path.
- Drives the `h_count`/`v_count` buses consumed by the background generator and the pixel mux, plus `hsync`, `vsync` and `de` for the TMDS encoder.
- All outputs are registered and mutually aligned, so downstream per-pixel logic sees the coordinates and the matching blanking state in the same cycle.
- A pixel-enable input lets the block run from a faster system clock.

## Interface
- `H_ACTIVE`, default 640: visible pixels per line.
- `H_FP`, default 16: horizontal front porch, in pixels.
- `H_SYNC`, default 96: hsync width, in pixels.
- `H_BP`, default 48: horizontal back porch, in pixels.
- `V_ACTIVE`, default 480: visible lines per frame.
- `V_FP`, default 10: vertical front porch, in lines.
- `V_SYNC`, default 2: vsync width, in lines.
- `V_BP`, default 33: vertical back porch, in lines.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-low reset.
- `pix_en` in 1: pixel advance strobe; tie high for a 25.175 MHz `clk`.
- `h_count` out 10: x coordinate, 0..H_TOTAL-1.
- `v_count` out 10: y coordinate, 0..V_TOTAL-1.
- `hsync` out 1: horizontal sync, active-low.
- `vsync` out 1: vertical sync, active-low.
- `de` out 1: high when `h_count`<H_ACTIVE and `v_count`<V_ACTIVE.
- `line_start` out 1: one-`clk` pulse when `h_count` becomes 0.
- `frame_start` out 1: one-`clk` pulse when (`h_count`,`v_count`) becomes (0,0).
- `frame_cnt` out 8: frames started modulo 256 (see Configuration).

## Operation
- Derived totals: H_TOTAL = sum of the H_* parameters (800); V_TOTAL = sum of the V_* parameters (525). Both must be ≤1024.
- Horizontal counter:
  - On a `clk` edge with `pix_en`=1, `h_count` increments.
  - At H_TOTAL-1 it wraps to 0, and `v_count` increments in the same edge.
  - `v_count` wraps from V_TOTAL-1 to 0.
- Outputs are decoded from the next-state counter values and registered together with the counters, so they are never one pixel stale.
  - `hsync`=0 iff H_ACTIVE+H_FP ≤ `h_count` < H_ACTIVE+H_FP+H_SYNC (656..751).
  - `vsync`=0 iff V_ACTIVE+V_FP ≤ `v_count` < V_ACTIVE+V_FP+V_SYNC (490..491). vsync changes only when `h_count` wraps.
- `pix_en`=0: counters, `hsync`, `vsync` and `de` hold their values. `line_start` and `frame_start` are forced to 0.
- Pulses:
  - `line_start`=1 for exactly the `clk` cycle after the advancing edge that loaded `h_count`=0.
  - `frame_start` additionally requires the next `v_count`=0.
  - Both are cleared on the following `clk` edge regardless of `pix_en`.
- Reset values while `rst`=0: `h_count`=H_TOTAL-1, `v_count`=V_TOTAL-1, `hsync`=1, `vsync`=1, `de`=0, `line_start`=0, `frame_start`=0, `frame_cnt`=0.
  - These match the decode of the last blanking position.
  - The first advance after reset therefore produces (0,0), `de`=1, and `line_start`=`frame_start`=1.
- Reset mid-frame takes priority over `pix_en` and returns to the reset values on that edge. No partial frame is flushed.

## Timing
- Latency is zero between the coordinates and `de`/`hsync`/`vsync`: all change on the same `clk` edge.
- Downstream combinational consumers (e.g. colour lookup) see coordinates and `de` in the same cycle.
- Pulses (`line_start`, `frame_start`) are one `clk` wide even when `pix_en` is a 1-in-4 strobe.
- With `pix_en` always high, one frame is 420000 `clk` cycles and one line is 800 cycles.
- With `pix_en` high 1 in N cycles, the counters are a piecewise-constant function of time. Hold time per pixel is N `clk` cycles.

## Configuration
- `VTG_FRAME_CNT_EN` defined:
  - `frame_cnt` increments by 1 on every edge that asserts `frame_start`, wrapping 255→0.
  - The first frame after reset reads 1.
- `VTG_FRAME_CNT_EN` undefined: the counter logic is not compiled and `frame_cnt` is tied to 8'h00.

## Test plan
- Reset release, `pix_en`=1: first edge gives `h_count`=0, `v_count`=0, `de`=1, `frame_start`=1, `hsync`=`vsync`=1. After 639 more edges: `h_count`=639, `de`=1. Next edge: `h_count`=640, `de`=0.
- Horizontal sync: `hsync` falls on the edge loading `h_count`=656 and rises on the edge loading 752. Exactly 96 low cycles per line.
- Vertical: one full frame → `vsync` low for exactly 1600 `clk` cycles (`v_count` 490–491). `frame_start` period is 420000 cycles. `line_start` count per frame is 525.
- `pix_en` asserted 1 of every 4 cycles: each coordinate is held 4 cycles, `line_start` is 1 cycle wide, and the frame period is 1680000 cycles.
- Reset asserted at (320,200): next edge outputs (799,524), `de`=0. On release, the first advance gives (0,0) with `frame_start`=1.
- With `VTG_FRAME_CNT_EN`: after 256 frames `frame_cnt`=0, after 257 frames `frame_cnt`=1. Without the macro, `frame_cnt` stays 0 throughout.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Raster timing generator for the 640x480@60 output path: coordinates, syncs, de and pulses.
// Optional frame counter is compiled in when VTG_FRAME_CNT_EN is defined.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_en,
  output logic [9:0] h_count,
  output logic [9:0] v_count,
  output logic       hsync,
  output logic       vsync,
  output logic       de,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_cnt
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0]  H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
  // 11-bit bounds so a sync pulse ending exactly at 1024 still compares correctly
  localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
  localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
  localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] h_q, h_d, v_q, v_d;
  logic [9:0] h_nxt, v_nxt;
  logic       hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
  logic       line_q, line_d, frame_q, frame_d;

  always_comb begin
    h_nxt = (h_q == H_LAST) ? 10'd0 : h_q + 10'd1;
    v_nxt = v_q;
    if (h_q == H_LAST) begin
      v_nxt = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
    end

    h_d     = h_q;
    v_d     = v_q;
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    de_d    = de_q;
    line_d  = 1'b0;
    frame_d = 1'b0;

    // Decode from next-state counters so outputs land on the same edge as the coordinates
    if (pix_en) begin
      h_d     = h_nxt;
      v_d     = v_nxt;
      hsync_d = !(({1'b0, h_nxt} >= HS_BEG) && ({1'b0, h_nxt} < HS_END));
      vsync_d = !(({1'b0, v_nxt} >= VS_BEG) && ({1'b0, v_nxt} < VS_END));
      de_d    = ({1'b0, h_nxt} < H_ACT) && ({1'b0, v_nxt} < V_ACT);
      line_d  = (h_nxt == 10'd0);
      frame_d = (h_nxt == 10'd0) && (v_nxt == 10'd0);
    end
  end

  // Reset values equal the decode of the last blanking position (H_TOTAL-1, V_TOTAL-1)
  always_ff @(posedge clk) begin
    if (!rst) begin
      h_q     <= H_LAST;
      v_q     <= V_LAST;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      de_q    <= 1'b0;
      line_q  <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
      line_q  <= line_d;
      frame_q <= frame_d;
    end
  end

`ifdef VTG_FRAME_CNT_EN
  logic [7:0] fcnt_q, fcnt_d;

  always_comb begin
    fcnt_d = fcnt_q;
    if (frame_d) begin
      fcnt_d = fcnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fcnt_q <= 8'd0;
    end else begin
      fcnt_q <= fcnt_d;
    end
  end

  assign frame_cnt = fcnt_q;
`else
  assign frame_cnt = 8'h00;
`endif

  assign h_count     = h_q;
  assign v_count     = v_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign line_start  = line_q;
  assign frame_start = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: a default-sized instance for line-level timing and a small-raster
// instance (15x8) for frame-level timing, reset and frame counter behaviour.
module tb_vga_timing_gen;

`ifdef VTG_FRAME_CNT_EN
  localparam bit FcEn = 1'b1;
`else
  localparam bit FcEn = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_d, pen_d, rst_s, pen_s;
  logic [9:0] hd, vd, hs, vs;
  logic       hsd, vsd, ded, lsd, fsd;
  logic       hss, vss, des, lss, fss;
  logic [7:0] fcd, fcs;

  vga_timing_gen dut_d (
    .clk(clk), .rst(rst_d), .pix_en(pen_d),
    .h_count(hd), .v_count(vd), .hsync(hsd), .vsync(vsd), .de(ded),
    .line_start(lsd), .frame_start(fsd), .frame_cnt(fcd)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut_s (
    .clk(clk), .rst(rst_s), .pix_en(pen_s),
    .h_count(hs), .v_count(vs), .hsync(hss), .vsync(vss), .de(des),
    .line_start(lss), .frame_start(fss), .frame_cnt(fcs)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input int unsigned act, input int unsigned exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lows, first_low, rise_h, ls_cnt, fs_cnt, hold_bad, exp_h;
    int vs_low, hs_low, de_cnt, fs_first, fs_second;
    rst_d = 1'b0; pen_d = 1'b1; rst_s = 1'b0; pen_s = 1'b1;
    step(); step();

    // Reset state of the default instance
    check_val("rst_h", hd, 799);
    check_val("rst_v", vd, 524);
    check_val("rst_sync", {hsd, vsd}, 2'b11);
    check_val("rst_de_pulses", {ded, lsd, fsd}, 3'b000);
    check_val("rst_fcnt", fcd, 0);

    rst_d = 1'b1;
    step();
    check_val("first_hv", {hd, vd}, 20'd0);
    check_val("first_de_ls_fs", {ded, lsd, fsd}, 3'b111);
    check_val("first_sync", {hsd, vsd}, 2'b11);
    check_val("first_fcnt", fcd, FcEn ? 1 : 0);

    repeat (639) step();
    check_val("h639", hd, 639);
    check_val("h639_de_fs", {ded, fsd, lsd}, 3'b100);
    step();
    check_val("h640", hd, 640);
    check_val("h640_de", ded, 0);

    // Rest of line 0: locate hsync edges and count low cycles
    lows = 0; first_low = -1; rise_h = -1;
    for (int i = 0; i < 160; i++) begin
      step();
      if (!hsd) begin
        lows++;
        if (first_low < 0) first_low = hd;
      end else if (lows > 0 && rise_h < 0) begin
        rise_h = hd;
      end
    end
    check_val("hs_low_cnt", lows, 96);
    check_val("hs_fall_h", first_low, 656);
    check_val("hs_rise_h", rise_h, 752);
    check_val("wrap_hv", {hd, vd}, {10'd0, 10'd1});
    check_val("wrap_ls_fs_de", {lsd, fsd, ded}, 3'b101);
    step();
    check_val("ls_width", lsd, 0);
    check_val("h1", hd, 1);

    // 1-in-4 strobe: advance h from 1 through the wrap to 0
    exp_h = 1; hold_bad = 0; ls_cnt = 0; fs_cnt = 0;
    for (int i = 0; i < 799; i++) begin
      pen_d = 1'b1;
      step();
      exp_h = (exp_h + 1) % 800;
      if (hd != 10'(exp_h)) hold_bad++;
      if (lsd) ls_cnt++;
      if (fsd) fs_cnt++;
      pen_d = 1'b0;
      for (int j = 0; j < 3; j++) begin
        step();
        if (hd != 10'(exp_h)) hold_bad++;
        if (lsd) ls_cnt++;
        if (fsd) fs_cnt++;
      end
    end
    check_val("strobe_hold_bad", hold_bad, 0);
    check_val("strobe_ls_cycles", ls_cnt, 1);
    check_val("strobe_fs_cycles", fs_cnt, 0);
    check_val("strobe_end_hv", {hd, vd}, {10'd0, 10'd2});

    // Small raster: H_TOTAL=15, V_TOTAL=8, frame=120 cycles
    check_val("s_rst_hv", {hs, vs}, {10'd14, 10'd7});
    rst_s = 1'b1;
    vs_low = 0; hs_low = 0; de_cnt = 0; ls_cnt = 0; fs_cnt = 0;
    fs_first = -1; fs_second = -1;
    for (int i = 1; i <= 240; i++) begin
      step();
      if (!vss) vs_low++;
      if (!hss) hs_low++;
      if (des) de_cnt++;
      if (lss) ls_cnt++;
      if (fss) begin
        fs_cnt++;
        if (fs_first < 0) fs_first = i;
        else if (fs_second < 0) fs_second = i;
      end
    end
    check_val("s_vs_low", vs_low, 60);
    check_val("s_hs_low", hs_low, 48);
    check_val("s_de_cnt", de_cnt, 64);
    check_val("s_ls_cnt", ls_cnt, 16);
    check_val("s_fs_cnt", fs_cnt, 2);
    check_val("s_fs_first", fs_first, 1);
    check_val("s_fs_period", fs_second - fs_first, 120);

    // Reset mid-frame at (5,3)
    repeat (51) step();
    check_val("s_at_5_3", {hs, vs}, {10'd5, 10'd3});
    rst_s = 1'b0;
    step();
    check_val("s_midrst_hv", {hs, vs}, {10'd14, 10'd7});
    check_val("s_midrst_de_sync", {des, hss, vss}, 3'b011);
    check_val("s_midrst_fcnt", fcs, 0);
    rst_s = 1'b1;
    step();
    check_val("s_rel_hv", {hs, vs}, 20'd0);
    check_val("s_rel_fs", {fss, lss, des}, 3'b111);
    check_val("s_rel_fcnt", fcs, FcEn ? 1 : 0);

    repeat (255 * 120) step();
    check_val("s_fcnt_256", fcs, 0);
    check_val("s_fs_256", fss, 1);
    repeat (120) step();
    check_val("s_fcnt_257", fcs, FcEn ? 1 : 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
